// File: rtl/vcfg_sequencer.sv
// vcfg_sequencer: vector configuration controller for vsetvli / vsetivli / vsetvl.
// Validates the requested vtype, computes the new vl, and owns the architectural
// vl/vtype registers. A vtype change waits for in-flight vector instructions to drain.
// Optional build macro: VCFG_STALL_CNT_EN enables a saturating drain-stall cycle counter
// on stall_cycles_o; without it the port is tied to zero.

// Checker: a retire with nothing outstanding is a backend protocol error.
module vcfg_sequencer_chk #(
  parameter int PEND_W = 4
) (
  input logic              clk,
  input logic              rst,
  input logic              retire,
  input logic              issue_fire,
  input logic [PEND_W-1:0] pending
);
  property p_no_underflow;
    @(posedge clk) disable iff (rst) !(retire && !issue_fire && (pending == {PEND_W{1'b0}}));
  endproperty
  a_no_underflow: assert property (p_no_underflow);
endmodule

module vcfg_sequencer #(
  parameter int VLEN       = 4096,
  parameter int ELEN       = 64,
  parameter int MaxPending = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [1:0]             req_kind_i,
  input  logic [4:0]             req_rs1_idx_i,
  input  logic [4:0]             req_rd_idx_i,
  input  logic [63:0]            req_avl_i,
  input  logic [63:0]            req_vtype_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [63:0]            resp_vl_o,
  output logic [4:0]             resp_rd_idx_o,
  output logic [$clog2(VLEN):0]  vl_o,
  output logic [8:0]             vtype_o,
  input  logic                   issue_valid_i,
  output logic                   issue_ready_o,
  input  logic                   retire_i,
  output logic [31:0]            stall_cycles_o
);
  localparam int VL_W   = $clog2(VLEN) + 1;
  localparam int PEND_W = $clog2(MaxPending + 1);
  // vsew encoding of ELEN (SEW = 8 << vsew)
  localparam logic [3:0]        ELEN_IDX  = 4'($clog2(ELEN) - 3);
  localparam logic [63:0]       VLEN_W64  = 64'(VLEN);
  localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MaxPending);
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_ZERO = PEND_W'(0);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CHECK  = 3'd1;
  localparam logic [2:0] ST_DRAIN  = 3'd2;
  localparam logic [2:0] ST_COMMIT = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  logic [2:0]        state_r;
  logic [PEND_W-1:0] pending_r;
  logic [PEND_W-1:0] pending_nxt_s;
  logic [1:0]        kind_r;
  logic [4:0]        rs1_r;
  logic [4:0]        rd_r;
  logic [63:0]       avl_r;
  logic [63:0]       vtype_req_r;
  logic [8:0]        cand_r;
  logic [8:0]        cand_s;
  logic [8:0]        vtype_r;
  logic [VL_W-1:0]   vl_r;
  logic              resp_valid_r;
  logic [63:0]       resp_vl_r;
  logic [4:0]        resp_rd_r;
  logic              idle_s;
  logic              issue_fire_s;
  logic              cand_ill_s;
  logic              vtype_changed_s;
  logic [2:0]        frac_sh_s;
  logic [3:0]        sew_frac_s;
  logic [63:0]       vlmax_base_s;
  logic [63:0]       vlmax_s;
  logic [63:0]       avl_sel_s;
  logic [63:0]       vl_new_s;

  assign idle_s        = (state_r == ST_IDLE);
  assign req_ready_o   = idle_s;
  assign issue_ready_o = idle_s && (pending_r < PEND_MAX);
  assign issue_fire_s  = issue_valid_i && issue_ready_o;

  // Pending-count update: simultaneous issue and retire cancel; retire at zero is dropped.
  always_comb begin
    pending_nxt_s = pending_r;
    if (issue_fire_s && !retire_i) begin
      pending_nxt_s = pending_r + PEND_ONE;
    end else if (!issue_fire_s && retire_i && (pending_r != PEND_ZERO)) begin
      pending_nxt_s = pending_r - PEND_ONE;
    end else begin
      pending_nxt_s = pending_r;
    end
  end

  // Candidate vtype: legality check of the latched request (fractional LMUL caps SEW at ELEN*LMUL).
  always_comb begin
    cand_ill_s = 1'b0;
    frac_sh_s  = 3'd0;
    case (vtype_req_r[2:0])
      3'b101:  frac_sh_s = 3'd3;
      3'b110:  frac_sh_s = 3'd2;
      3'b111:  frac_sh_s = 3'd1;
      default: frac_sh_s = 3'd0;
    endcase
    sew_frac_s = {1'b0, vtype_req_r[5:3]} + {1'b0, frac_sh_s};
    if (vtype_req_r[2:0] == 3'b100) begin
      cand_ill_s = 1'b1;
    end else if ({1'b0, vtype_req_r[5:3]} > ELEN_IDX) begin
      cand_ill_s = 1'b1;
    end else if (vtype_req_r[63:8] != 56'd0) begin
      cand_ill_s = 1'b1;
    end else if (sew_frac_s > ELEN_IDX) begin
      cand_ill_s = 1'b1;
    end else begin
      cand_ill_s = 1'b0;
    end
    if (cand_ill_s) begin
      cand_s = 9'h100;
    end else begin
      cand_s = {1'b0, vtype_req_r[7:0]};
    end
  end

  // vta/vma changes do not affect in-flight instructions, so they never force a drain.
  assign vtype_changed_s = ({cand_s[8], cand_s[5:0]} != {vtype_r[8], vtype_r[5:0]});

  // New vl from the committed candidate: VLMAX scaled by LMUL, AVL chosen by the x0 rules.
  always_comb begin
    vlmax_base_s = VLEN_W64 >> ({1'b0, cand_r[5:3]} + 4'd3);
    case (cand_r[2:0])
      3'b000:  vlmax_s = vlmax_base_s;
      3'b001:  vlmax_s = vlmax_base_s << 1;
      3'b010:  vlmax_s = vlmax_base_s << 2;
      3'b011:  vlmax_s = vlmax_base_s << 3;
      3'b101:  vlmax_s = vlmax_base_s >> 3;
      3'b110:  vlmax_s = vlmax_base_s >> 2;
      3'b111:  vlmax_s = vlmax_base_s >> 1;
      default: vlmax_s = vlmax_base_s;
    endcase
    if (kind_r == 2'd1) begin
      avl_sel_s = avl_r;
    end else if (rs1_r != 5'd0) begin
      avl_sel_s = avl_r;
    end else if (rd_r != 5'd0) begin
      avl_sel_s = {64{1'b1}};
    end else begin
      avl_sel_s = {{(64 - VL_W){1'b0}}, vl_r};
    end
    if (cand_r[8]) begin
      vl_new_s = 64'd0;
    end else if (avl_sel_s < vlmax_s) begin
      vl_new_s = avl_sel_s;
    end else begin
      vl_new_s = vlmax_s;
    end
  end

  // Request sequencing and architectural vl/vtype state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= ST_IDLE;
      kind_r       <= 2'd0;
      rs1_r        <= 5'd0;
      rd_r         <= 5'd0;
      avl_r        <= 64'd0;
      vtype_req_r  <= 64'd0;
      cand_r       <= 9'h100;
      vtype_r      <= 9'h100;
      vl_r         <= {VL_W{1'b0}};
      resp_valid_r <= 1'b0;
      resp_vl_r    <= 64'd0;
      resp_rd_r    <= 5'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid_i) begin
            kind_r      <= req_kind_i;
            rs1_r       <= req_rs1_idx_i;
            rd_r        <= req_rd_idx_i;
            avl_r       <= req_avl_i;
            vtype_req_r <= req_vtype_i;
            state_r     <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          cand_r <= cand_s;
          if (vtype_changed_s && (pending_r != PEND_ZERO)) begin
            state_r <= ST_DRAIN;
          end else begin
            state_r <= ST_COMMIT;
          end
        end
        ST_DRAIN: begin
          if (pending_r == PEND_ZERO) begin
            state_r <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          vl_r         <= vl_new_s[VL_W-1:0];
          vtype_r      <= cand_r;
          resp_vl_r    <= vl_new_s;
          resp_rd_r    <= rd_r;
          resp_valid_r <= 1'b1;
          state_r      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready_i) begin
            resp_valid_r <= 1'b0;
            state_r      <= ST_IDLE;
          end
        end
        default: begin
          resp_valid_r <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  // Outstanding vector instruction count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_r <= PEND_ZERO;
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

`ifdef VCFG_STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of cycles spent waiting for the drain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_r <= 32'd0;
    end else if ((state_r == ST_DRAIN) && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cycles_o = stall_cnt_r;
`else
  assign stall_cycles_o = 32'd0;
`endif

  assign resp_valid_o  = resp_valid_r;
  assign resp_vl_o     = resp_vl_r;
  assign resp_rd_idx_o = resp_rd_r;
  assign vl_o          = vl_r;
  assign vtype_o       = vtype_r;

  vcfg_sequencer_chk #(.PEND_W(PEND_W)) u_chk (
    .clk        (clk_i),
    .rst        (rst_i),
    .retire     (retire_i),
    .issue_fire (issue_fire_s),
    .pending    (pending_r)
  );
endmodule

// File: tb/tb_vcfg_sequencer.sv
// Self-checking bench for vcfg_sequencer: directed scenarios plus randomized requests
// checked against a reference model computed from SEW/LMUL arithmetic.
module tb_vcfg_sequencer;
  localparam int VLEN = 4096;
  localparam int ELEN = 64;
  localparam int MAXP = 8;
`ifdef VCFG_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [1:0]  req_kind_i = 2'd0;
  logic [4:0]  req_rs1_idx_i = 5'd0;
  logic [4:0]  req_rd_idx_i = 5'd0;
  logic [63:0] req_avl_i = 64'd0;
  logic [63:0] req_vtype_i = 64'd0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b1;
  logic [63:0] resp_vl_o;
  logic [4:0]  resp_rd_idx_o;
  logic [12:0] vl_o;
  logic [8:0]  vtype_o;
  logic        issue_valid_i = 1'b0;
  logic        issue_ready_o;
  logic        retire_i = 1'b0;
  logic [31:0] stall_cycles_o;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [63:0] m_vl = 64'd0;
  logic [8:0]  m_vtype = 9'h100;

  always #5 clk_i = ~clk_i;

  vcfg_sequencer #(.VLEN(VLEN), .ELEN(ELEN), .MaxPending(MAXP)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_kind_i     (req_kind_i),
    .req_rs1_idx_i  (req_rs1_idx_i),
    .req_rd_idx_i   (req_rd_idx_i),
    .req_avl_i      (req_avl_i),
    .req_vtype_i    (req_vtype_i),
    .resp_valid_o   (resp_valid_o),
    .resp_ready_i   (resp_ready_i),
    .resp_vl_o      (resp_vl_o),
    .resp_rd_idx_o  (resp_rd_idx_o),
    .vl_o           (vl_o),
    .vtype_o        (vtype_o),
    .issue_valid_i  (issue_valid_i),
    .issue_ready_o  (issue_ready_o),
    .retire_i       (retire_i),
    .stall_cycles_o (stall_cycles_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference: legality from SEW/LMUL as numbers, VLMAX = VLEN*LMUL/SEW, AVL by x0 rules.
  task automatic model_apply(input logic [1:0] kind, input logic [4:0] rs1, input logic [4:0] rd,
                             input logic [63:0] avl, input logic [63:0] vt);
    longint unsigned sew, num, den, vlmax;
    logic [63:0] a;
    int lm;
    bit ill;
    lm  = int'(vt[2:0]);
    sew = 64'd8 << vt[5:3];
    ill = (vt[63:8] != 56'd0) || (lm == 4) || (sew > 64'(ELEN));
    if (lm < 4) begin
      num = 64'd1 << lm;
      den = 64'd1;
    end else begin
      num = 64'd1;
      den = 64'd1 << (8 - lm);
    end
    if (den > 64'd1 && sew * den > 64'(ELEN)) ill = 1'b1;
    vlmax = 64'(VLEN) * num / (sew * den);
    if (kind == 2'd1)     a = avl;
    else if (rs1 != 5'd0) a = avl;
    else if (rd != 5'd0)  a = {64{1'b1}};
    else                  a = m_vl;
    if (ill) begin
      m_vl    = 64'd0;
      m_vtype = 9'h100;
    end else begin
      m_vl    = (a < vlmax) ? a : vlmax;
      m_vtype = {1'b0, vt[7:0]};
    end
  endtask

  // Drive one request, then wait (bounded) for the response; lat = cycles after accept, -1 on timeout.
  task automatic send_req(input logic [1:0] kind, input logic [4:0] rs1, input logic [4:0] rd,
                          input logic [63:0] avl, input logic [63:0] vt,
                          output int lat, output logic ready_seen);
    ready_seen    = req_ready_o;
    req_valid_i   = 1'b1;
    req_kind_i    = kind;
    req_rs1_idx_i = rs1;
    req_rd_idx_i  = rd;
    req_avl_i     = avl;
    req_vtype_i   = vt;
    tick();
    req_valid_i = 1'b0;
    model_apply(kind, rs1, rd, avl, vt);
    lat = 0;
    while (!resp_valid_o && lat < 200) begin
      tick();
      lat++;
    end
    if (!resp_valid_o) lat = -1;
  endtask

  task automatic ack();
    resp_ready_i = 1'b1;
    tick();
  endtask

  task automatic do_issue(input int n);
    for (int i = 0; i < n; i++) begin
      issue_valid_i = 1'b1;
      tick();
      issue_valid_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick(); tick(); tick();
    rst_i = 1'b0;
    checks++;
    if ({resp_valid_o, vtype_o, vl_o} !== {1'b0, 9'h100, 13'd0}) begin
      errors++;
      $display("FAIL reset_arch: got valid=%0b vtype=%0h vl=%0d, expected valid=0 vtype=100 vl=0", resp_valid_o, vtype_o, vl_o);
    end
    checks++;
    if ({resp_vl_o, resp_rd_idx_o, stall_cycles_o} !== {64'd0, 5'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_resp: got resp_vl=%0d rd=%0d stall=%0d, expected 0 0 0", resp_vl_o, resp_rd_idx_o, stall_cycles_o);
    end
    checks++;
    if ({req_ready_o, issue_ready_o} !== 2'b11) begin
      errors++;
      $display("FAIL reset_ready: got req_ready=%0b issue_ready=%0b, expected 1 1", req_ready_o, issue_ready_o);
    end
  endtask

  task automatic test_basic();
    int lat; logic rs;
    send_req(2'd0, 5'd5, 5'd7, 64'd100, 64'h10, lat, rs);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL basic_latency: got %0d expected 2", lat); end
    checks++;
    if ({resp_vl_o, vl_o, vtype_o, resp_rd_idx_o} !== {64'd100, 13'd100, 9'h010, 5'd7}) begin
      errors++;
      $display("FAIL basic_result: got resp_vl=%0d vl=%0d vtype=%0h rd=%0d, expected 100 100 010 7", resp_vl_o, vl_o, vtype_o, resp_rd_idx_o);
    end
    ack();
  endtask

  task automatic test_avl_rules();
    int lat; logic rs;
    send_req(2'd0, 5'd5, 5'd1, 64'd5000, 64'h03, lat, rs);
    checks++;
    if ({resp_vl_o, vl_o} !== {64'd4096, 13'd4096}) begin
      errors++; $display("FAIL avl_clamp: got resp_vl=%0d vl=%0d expected 4096", resp_vl_o, vl_o);
    end
    ack();
    send_req(2'd0, 5'd0, 5'd1, 64'd12345, 64'h0F, lat, rs);
    checks++;
    if ({resp_vl_o, vl_o, vtype_o} !== {64'd128, 13'd128, 9'h00F}) begin
      errors++; $display("FAIL avl_x0_rd: got resp_vl=%0d vl=%0d vtype=%0h expected 128 128 00f", resp_vl_o, vl_o, vtype_o);
    end
    ack();
    send_req(2'd0, 5'd0, 5'd0, 64'd3, 64'h0F, lat, rs);
    checks++;
    if ({resp_vl_o, vl_o} !== {64'd128, 13'd128}) begin
      errors++; $display("FAIL avl_x0_x0: got resp_vl=%0d vl=%0d expected 128", resp_vl_o, vl_o);
    end
    ack();
  endtask

  task automatic test_illegal();
    int lat; logic rs;
    send_req(2'd0, 5'd5, 5'd2, 64'd50, 64'h04, lat, rs);
    checks++;
    if ({resp_vl_o, vl_o, vtype_o} !== {64'd0, 13'd0, 9'h100}) begin
      errors++; $display("FAIL illegal_vlmul: got resp_vl=%0d vl=%0d vtype=%0h expected 0 0 100", resp_vl_o, vl_o, vtype_o);
    end
    ack();
    send_req(2'd0, 5'd5, 5'd2, 64'd50, 64'h110, lat, rs);
    checks++;
    if ({resp_vl_o, vl_o, vtype_o} !== {64'd0, 13'd0, 9'h100}) begin
      errors++; $display("FAIL illegal_reserved: got resp_vl=%0d vl=%0d vtype=%0h expected 0 0 100", resp_vl_o, vl_o, vtype_o);
    end
    ack();
  endtask

  task automatic test_drain();
    int lat; logic rs;
    logic [31:0] stall_exp;
    send_req(2'd0, 5'd5, 5'd1, 64'd50, 64'h10, lat, rs);
    ack();
    do_issue(3);
    req_valid_i = 1'b1; req_kind_i = 2'd0; req_rs1_idx_i = 5'd5; req_rd_idx_i = 5'd2;
    req_avl_i = 64'd20; req_vtype_i = 64'h08;
    tick();
    req_valid_i = 1'b0;
    model_apply(2'd0, 5'd5, 5'd2, 64'd20, 64'h08);
    // three hold cycles: the first leaves CHECK, the other two are spent in DRAIN
    for (int i = 0; i < 3; i++) begin
      issue_valid_i = 1'b1;
      tick();
      checks++;
      if ({issue_ready_o, resp_valid_o, req_ready_o} !== 3'b000) begin
        errors++; $display("FAIL drain_hold: got issue_ready=%0b resp_valid=%0b req_ready=%0b expected 0 0 0", issue_ready_o, resp_valid_o, req_ready_o);
      end
    end
    issue_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      retire_i = 1'b1;
      tick();
      checks++;
      if ({issue_ready_o, resp_valid_o} !== 2'b00) begin
        errors++; $display("FAIL drain_retire%0d: got issue_ready=%0b resp_valid=%0b expected 0 0", i, issue_ready_o, resp_valid_o);
      end
    end
    retire_i = 1'b0;
    lat = 0;
    while (!resp_valid_o && lat < 200) begin tick(); lat++; end
    checks++;
    if (lat !== 2 || !resp_valid_o) begin errors++; $display("FAIL drain_latency: got %0d expected 2", lat); end
    checks++;
    if ({resp_vl_o, vl_o, vtype_o} !== {m_vl, m_vl[12:0], m_vtype} || m_vl !== 64'd20) begin
      errors++; $display("FAIL drain_result: got resp_vl=%0d vl=%0d vtype=%0h expected 20 20 008", resp_vl_o, vl_o, vtype_o);
    end
    // DRAIN cycles: 2 waiting + 3 retiring + 1 observing zero
    stall_exp = STALL_EN ? 32'd6 : 32'd0;
    checks++;
    if (stall_cycles_o !== stall_exp) begin
      errors++; $display("FAIL drain_stall_cnt: got %0d expected %0d", stall_cycles_o, stall_exp);
    end
    ack();
    checks++;
    if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL drain_release: got issue_ready=%0b expected 1", issue_ready_o); end
  endtask

  task automatic test_no_drain();
    int lat; logic rs;
    do_issue(3);
    send_req(2'd0, 5'd6, 5'd3, 64'd7, 64'h08, lat, rs);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL nodrain_latency: got %0d expected 2", lat); end
    checks++;
    if ({resp_vl_o, vl_o} !== {64'd7, 13'd7}) begin
      errors++; $display("FAIL nodrain_vl: got resp_vl=%0d vl=%0d expected 7", resp_vl_o, vl_o);
    end
    ack();
    // pending must still be 3: four more issues leave room for exactly one more
    do_issue(4);
    checks++;
    if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL pending_7_ready: got %0b expected 1", issue_ready_o); end
    do_issue(1);
    checks++;
    if (issue_ready_o !== 1'b0) begin errors++; $display("FAIL pending_full: got issue_ready=%0b expected 0", issue_ready_o); end
    for (int i = 0; i < MAXP; i++) begin
      retire_i = 1'b1;
      tick();
    end
    retire_i = 1'b0;
    checks++;
    if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL pending_empty: got issue_ready=%0b expected 1", issue_ready_o); end
  endtask

  task automatic test_back_to_back();
    int lat; logic rs;
    send_req(2'd1, 5'd0, 5'd9, 64'd17, 64'h00, lat, rs);
    checks++;
    if ({lat == 2, resp_vl_o} !== {1'b1, 64'd17}) begin
      errors++; $display("FAIL b2b_first: got lat=%0d resp_vl=%0d expected 2 17", lat, resp_vl_o);
    end
    ack();
    send_req(2'd0, 5'd0, 5'd10, 64'd1, 64'h00, lat, rs);
    checks++;
    if ({rs, lat == 2, resp_vl_o, resp_rd_idx_o} !== {1'b1, 1'b1, 64'd512, 5'd10}) begin
      errors++; $display("FAIL b2b_second: got ready=%0b lat=%0d resp_vl=%0d rd=%0d expected 1 2 512 10", rs, lat, resp_vl_o, resp_rd_idx_o);
    end
    ack();
  endtask

  task automatic test_backpressure();
    int lat; logic rs;
    resp_ready_i = 1'b0;
    send_req(2'd0, 5'd7, 5'd4, 64'd33, 64'h11, lat, rs);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({resp_valid_o, resp_vl_o, req_ready_o} !== {1'b1, 64'd33, 1'b0}) begin
        errors++; $display("FAIL bp_hold%0d: got valid=%0b resp_vl=%0d req_ready=%0b expected 1 33 0", i, resp_valid_o, resp_vl_o, req_ready_o);
      end
    end
    ack();
    checks++;
    if ({resp_valid_o, req_ready_o} !== 2'b01) begin
      errors++; $display("FAIL bp_release: got valid=%0b req_ready=%0b expected 0 1", resp_valid_o, req_ready_o);
    end
  endtask

  task automatic test_reset_in_drain();
    int lat; logic rs; bit seen;
    do_issue(2);
    req_valid_i = 1'b1; req_kind_i = 2'd0; req_rs1_idx_i = 5'd5; req_rd_idx_i = 5'd1;
    req_avl_i = 64'd9; req_vtype_i = 64'h02;
    tick();
    req_valid_i = 1'b0;
    tick(); tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    m_vl = 64'd0; m_vtype = 9'h100;
    checks++;
    if ({vl_o, vtype_o, resp_valid_o, stall_cycles_o} !== {13'd0, 9'h100, 1'b0, 32'd0}) begin
      errors++; $display("FAIL rst_drain_state: got vl=%0d vtype=%0h valid=%0b stall=%0d expected 0 100 0 0", vl_o, vtype_o, resp_valid_o, stall_cycles_o);
    end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (resp_valid_o) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rst_drain_noresp: got response=1 expected 0"); end
    // vtype differs from the reset value; only a zero pending count avoids a drain
    send_req(2'd0, 5'd5, 5'd1, 64'd10, 64'h10, lat, rs);
    checks++;
    if ({lat == 2, resp_vl_o} !== {1'b1, 64'd10}) begin
      errors++; $display("FAIL rst_drain_pending: got lat=%0d resp_vl=%0d expected 2 10", lat, resp_vl_o);
    end
    ack();
  endtask

  task automatic test_random();
    int lat; logic rs;
    logic [1:0] kind; logic [4:0] rs1, rd; logic [63:0] avl, vt;
    int d;
    for (int n = 0; n < 40; n++) begin
      kind = 2'($urandom_range(0, 3));
      rs1  = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rd   = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      case ($urandom_range(0, 2))
        0:       avl = 64'($urandom_range(0, 300));
        1:       avl = {$urandom, $urandom};
        default: avl = 64'($urandom_range(4000, 5000));
      endcase
      if (kind == 2'd1) avl = 64'($urandom_range(0, 31));
      vt = 64'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) vt[8 + $urandom_range(0, 55)] = 1'b1;
      d = $urandom_range(0, 3);
      resp_ready_i = (d == 0);
      send_req(kind, rs1, rd, avl, vt, lat, rs);
      checks++;
      if ({rs, lat == 2} !== 2'b11) begin
        errors++; $display("FAIL rnd%0d_timing: got ready=%0b lat=%0d expected 1 2", n, rs, lat);
      end
      checks++;
      if ({resp_vl_o, resp_rd_idx_o} !== {m_vl, rd}) begin
        errors++; $display("FAIL rnd%0d_resp: vt=%0h avl=%0h got resp_vl=%0h rd=%0d expected %0h %0d", n, vt, avl, resp_vl_o, resp_rd_idx_o, m_vl, rd);
      end
      checks++;
      if ({vl_o, vtype_o} !== {m_vl[12:0], m_vtype}) begin
        errors++; $display("FAIL rnd%0d_arch: vt=%0h got vl=%0d vtype=%0h expected %0d %0h", n, vt, vl_o, vtype_o, m_vl, m_vtype);
      end
      for (int i = 1; i < d; i++) tick();
      ack();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_avl_rules();
    test_illegal();
    test_drain();
    test_no_drain();
    test_back_to_back();
    test_backpressure();
    test_reset_in_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vcfg_sequencer.md
Name: vcfg_sequencer

Overview:
- Vector configuration controller: executes vsetvli / vsetivli / vsetvl requests from the scalar dispatcher.
- Computes the new vl, validates vtype, and holds the architectural vl/vtype registers.
- Tracks in-flight vector instructions and stalls a vtype change until they drain.
- Sits between the dispatcher and the vector issue stage; its vl_o/vtype_o feed every lane and the CSR read path.

Parameters:
- VLEN, 4096, vector register length in bits (power of two, 128..65536).
- ELEN, 64, max supported SEW in bits (8/16/32/64).
- MaxPending, 8, max outstanding vector instructions tracked.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  config request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_kind_i  in  2  0=vsetvli 1=vsetivli 2=vsetvl (3 treated as 2)
- req_rs1_idx_i  in  5  rs1 register index (x0 rules)
- req_rd_idx_i  in  5  rd register index
- req_avl_i  in  64  rs1 value, or uimm5 zero-extended for vsetivli
- req_vtype_i  in  64  requested vtype: [2:0] vlmul, [5:3] vsew, [6] vta, [7] vma, [63:8] reserved
- resp_valid_o  out  1  result valid
- resp_ready_i  in  1  result consumed
- resp_vl_o  out  64  new vl, zero-extended, written to rd
- resp_rd_idx_o  out  5  destination index
- vl_o  out  $clog2(VLEN)+1  current vl
- vtype_o  out  9  current vtype {vill,vma,vta,vsew[2:0],vlmul[2:0]}
- issue_valid_i  in  1  vector instr dispatched to backend
- issue_ready_o  out  1  dispatch permitted
- retire_i  in  1  vector instr completed
- stall_cycles_o  out  32  drain-stall cycle count (see Optional Feature)

Behaviour:
- Reset: state IDLE, vl_o=0, vtype_o=9'h100 (vill=1), pending=0, resp_valid_o=0, resp_vl_o=0, resp_rd_idx_o=0, stall_cycles_o=0.
- Reset asserted in any state overrides everything; an in-flight request is dropped without response.
- req_ready_o = (state==IDLE).
- issue_ready_o = (state==IDLE) && (pending < MaxPending).
- Pending counter:
  - +1 on issue_valid_i & issue_ready_o; -1 on retire_i.
  - Both in the same cycle: no change.
  - retire_i at 0: ignored, counter stays 0 (assertion flags it).
- IDLE→CHECK on request accept; request fields are latched. An issue in the same IDLE cycle is counted first (it is older).
- CHECK (1 cycle): compute the candidate vtype.
  - vill=1 if any of:
    - vlmul==3'b100;
    - vsew encodes SEW>ELEN;
    - req_vtype_i[63:8] != 0;
    - fractional LMUL with SEW > ELEN*LMUL, e.g. SEW64 with LMUL 1/2 when ELEN=64.
  - Go to DRAIN if the candidate's {vill,vsew,vlmul} differs from vtype_o and pending != 0; otherwise go to COMMIT.
- DRAIN: hold until pending==0, counting cycles, then go to COMMIT. No new issues are accepted in DRAIN.
- COMMIT (1 cycle):
  - VLMAX = (VLEN >> (vsew+3)) scaled by LMUL: left shift 0..3 for LMUL 1..8, right shift 1..3 for 1/2..1/8.
  - AVL selection:
    - vsetivli: AVL = req_avl_i.
    - rs1!=x0: AVL = req_avl_i.
    - rs1==x0, rd!=x0: AVL = all ones.
    - rs1==x0, rd==x0: AVL = current vl_o.
  - vl = min(AVL, VLMAX), with 64-bit unsigned compare.
  - If vill: vl=0 and vtype=9'h100.
  - Register vl_o, vtype_o, resp_vl_o and resp_rd_idx_o at the end of COMMIT, then go to RESP.
- RESP: resp_valid_o=1; hold outputs stable until resp_ready_i, then go to IDLE.
- Latency with no drain: accept at edge T; resp_valid_o high from cycle T+2 onward; the new vl_o is visible from T+2.
- Back-to-back requests: the next request is accepted in the first IDLE cycle after the RESP handshake.

Optional Feature:
- VCFG_STALL_CNT_EN defined: stall_cycles_o counts each cycle spent in DRAIN. It is a saturating 32-bit counter, cleared only by reset.
- Undefined: no counter logic; stall_cycles_o tied to 0.

Test Plan:
- Basic vsetvli: VLEN=4096; vsetvli rs1=x5, AVL=100, vtype=SEW32 LMUL1 (0x10), resp_ready_i=1 → resp_vl_o=100, vl_o=100, vtype_o=9'h010, resp_valid_o high at T+2.
- AVL above VLMAX and rs1=x0 rules:
  - AVL=5000, SEW8 LMUL8 (0x03) → vl=4096.
  - Then rs1=x0, rd=x1, SEW16 LMUL1/2 (0x0F) → vl=128.
  - Then rs1=x0, rd=x0, same vtype → vl=128.
- Illegal vtype: vtype=0x04 (vlmul reserved) → vl_o=0, vtype_o=9'h100, resp_vl_o=0. Repeat with vtype bit 8 set → same result.
- Drain on vtype change: pending=3, request changes SEW → stays in DRAIN and issue_ready_o=0 until the third retire. resp_valid_o rises 2 cycles after pending reaches 0. stall_cycles_o equals the number of DRAIN cycles when VCFG_STALL_CNT_EN is defined.
- No drain when vtype is unchanged: pending=3, same vtype, new AVL=7 → resp at T+2 with vl=7, pending still 3.
- Reset and backpressure:
  - Reset during DRAIN → vl_o=0, vtype_o=9'h100, pending=0, no response issued.
  - resp_ready_i held low for 5 cycles → resp_valid_o and resp_vl_o stable for all 5 cycles, req_ready_o=0 throughout.
